reset_controller: RTL and testbench

RESET_CONTROLLER -- requirements
Module: reset_controller

---
 rtl/reset_controller.sv | 141 ++++++++++++++
 tb/tb_reset_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/reset_controller.sv
`default_nettype none
// ============================================================================
// Module   : reset_controller
// Brief    : Merges button, software and watchdog reset sources into a
//            stretched, registered core reset with sticky cause reporting.
// Revision : 1.0 - initial release
// ============================================================================
module reset_controller #(
  parameter int PULSE_CYCLES    = 16,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int WDT_WIDTH       = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_btn_n,
  input  logic                 i_sw_req,
  input  logic                 i_wdt_en,
  input  logic                 i_wdt_kick,
  input  logic [WDT_WIDTH-1:0] i_wdt_limit,
  input  logic                 i_cause_clr,
  output logic                 o_core_rst,
  output logic [3:0]           o_cause,
  output logic                 o_busy
);

  localparam int c_PULSE_W = $clog2(PULSE_CYCLES);
  localparam int c_DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_PULSE_W-1:0] c_PULSE_LAST = c_PULSE_W'(PULSE_CYCLES - 1);
  localparam logic [c_DEB_W-1:0]   c_DEB_LAST   = c_DEB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_ASSERT = 2'd1;
  localparam logic [1:0] c_ST_HOLD   = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_state_next;
  logic [c_PULSE_W-1:0] r_pulse_cnt;
  logic                 r_btn_meta;
  logic                 r_btn_sync;
  logic [c_DEB_W-1:0]   r_deb_cnt;
  logic                 r_btn_pressed;
  logic [WDT_WIDTH-1:0] r_wdt_cnt;
  logic                 w_wdt_armed;
  logic                 w_wdt_req;
  logic                 w_req_any;
  logic                 w_core_rst_next;
  logic                 r_core_rst;
  logic [3:0]           r_cause;

  // Button: two-flop synchronizer, idles high so reset never looks like a press
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_btn_meta <= 1'b1;
      r_btn_sync <= 1'b1;
    end else begin
      r_btn_meta <= i_btn_n;
      r_btn_sync <= r_btn_meta;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || r_btn_sync) begin
      r_deb_cnt     <= '0;
      r_btn_pressed <= 1'b0;
    end else if (r_deb_cnt == c_DEB_LAST) begin
      r_btn_pressed <= 1'b1;
    end else begin
      r_deb_cnt <= r_deb_cnt + c_DEB_W'(1);
    end
  end

  // Watchdog only runs in IDLE; firing clears it so it never wraps past the limit
  assign w_wdt_armed = i_wdt_en && (i_wdt_limit != '0) && (r_state == c_ST_IDLE);
  assign w_wdt_req   = w_wdt_armed && (r_wdt_cnt == i_wdt_limit);

  always_ff @(posedge i_clk) begin
    if (i_rst || !w_wdt_armed || i_wdt_kick || w_wdt_req) begin
      r_wdt_cnt <= '0;
    end else begin
      r_wdt_cnt <= r_wdt_cnt + WDT_WIDTH'(1);
    end
  end

  assign w_req_any = r_btn_pressed || i_sw_req || w_wdt_req;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= c_ST_ASSERT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE:   if (w_req_any) w_state_next = c_ST_ASSERT;
      c_ST_ASSERT: if (r_pulse_cnt == c_PULSE_LAST)
                     w_state_next = r_btn_pressed ? c_ST_HOLD : c_ST_IDLE;
      c_ST_HOLD:   if (!r_btn_pressed) w_state_next = c_ST_IDLE;
      default:     w_state_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_core_rst_next = (w_state_next != c_ST_IDLE);
    o_busy          = (r_state != c_ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state != c_ST_ASSERT) || (r_pulse_cnt == c_PULSE_LAST)) begin
      r_pulse_cnt <= '0;
    end else begin
      r_pulse_cnt <= r_pulse_cnt + c_PULSE_W'(1);
    end
  end

  // Registered from the next state so the pulse appears one cycle after a request
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_core_rst <= 1'b1;
    end else begin
      r_core_rst <= w_core_rst_next;
    end
  end

  // Clear is applied before the OR so a same-cycle set survives
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cause <= 4'b1000;
    end else begin
      r_cause <= (i_cause_clr ? 4'b0000 : r_cause) |
                 {1'b0, w_wdt_req, i_sw_req, r_btn_pressed};
    end
  end

  assign o_core_rst = r_core_rst;
  assign o_cause    = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_reset_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_controller
// Brief    : Directed and randomized bench for reset_controller against a
//            cycle-level behavioural model of pulse/hold/cause rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reset_controller;

  localparam int PULSE = 16;
  localparam int DEB   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_n;
  logic        sw_req;
  logic        wdt_en;
  logic        wdt_kick;
  logic [15:0] wdt_limit;
  logic        cause_clr;
  logic        core_rst;
  logic [3:0]  cause;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Model: remaining pulse cycles, hold flag, button sample history
  int         m_pulse_left;
  bit         m_hold;
  logic [3:0] m_cause;
  int         m_wdt;
  int         m_run;
  bit         m_pressed;
  bit [1:0]   m_pipe;

  reset_controller #(
    .PULSE_CYCLES    (PULSE),
    .DEBOUNCE_CYCLES (DEB),
    .WDT_WIDTH       (16)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_btn_n     (btn_n),
    .i_sw_req    (sw_req),
    .i_wdt_en    (wdt_en),
    .i_wdt_kick  (wdt_kick),
    .i_wdt_limit (wdt_limit),
    .i_cause_clr (cause_clr),
    .o_core_rst  (core_rst),
    .o_cause     (cause),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit busy_now = (m_pulse_left > 0) || m_hold;
    bit armed    = !busy_now && wdt_en && (wdt_limit != 16'd0);
    bit req_wdt  = armed && (m_wdt == int'(wdt_limit));
    bit req_btn  = m_pressed;
    bit req_sw   = sw_req;
    bit sampled  = m_pipe[1];
    if (rst) begin
      m_pulse_left = PULSE;
      m_hold       = 1'b0;
      m_cause      = 4'b1000;
      m_wdt        = 0;
      m_run        = 0;
      m_pressed    = 1'b0;
      m_pipe       = 2'b11;
    end else begin
      m_cause = (cause_clr ? 4'b0000 : m_cause) | {1'b0, req_wdt, req_sw, req_btn};
      if (m_pulse_left > 0) begin
        m_pulse_left--;
        if (m_pulse_left == 0 && m_pressed) m_hold = 1'b1;
      end else if (m_hold) begin
        if (!m_pressed) m_hold = 1'b0;
      end else if (req_btn || req_sw || req_wdt) begin
        m_pulse_left = PULSE;
      end
      m_wdt = (!armed || wdt_kick || req_wdt) ? 0 : m_wdt + 1;
      if (sampled) begin
        m_run     = 0;
        m_pressed = 1'b0;
      end else begin
        m_run++;
        if (m_run >= DEB) m_pressed = 1'b1;
      end
      m_pipe = {m_pipe[0], btn_n};
    end
  endtask

  task automatic step();
    bit exp_rst;
    @(posedge clk);
    model_edge();
    #1;
    exp_rst = (m_pulse_left > 0) || m_hold;
    check("core_rst", 32'(core_rst), 32'(exp_rst));
    check("busy", 32'(busy), 32'(exp_rst));
    check("cause", 32'(cause), 32'(m_cause));
  endtask

  initial begin
    int n;
    int lat;
    rst = 1'b1; btn_n = 1'b1; sw_req = 1'b0; wdt_en = 1'b0;
    wdt_kick = 1'b0; wdt_limit = 16'd0; cause_clr = 1'b0;

    repeat (3) step();
    check("rst_core", 32'(core_rst), 32'd1);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_cause", 32'(cause), 32'h8);

    // Power-on stretch
    rst = 1'b0;
    n = int'(core_rst);
    repeat (30) begin step(); n += int'(core_rst); end
    check("por_len", 32'(n), 32'd16);
    check("por_cause", 32'(cause), 32'h8);

    // Software request
    cause_clr = 1'b1; step(); cause_clr = 1'b0; step();
    check("clr_cause", 32'(cause), 32'h0);
    sw_req = 1'b1; step(); sw_req = 1'b0;
    n = int'(core_rst);
    repeat (30) begin step(); n += int'(core_rst); end
    check("sw_len", 32'(n), 32'd16);
    check("sw_cause", 32'(cause), 32'h2);

    // Short button glitch is filtered
    btn_n = 1'b0; repeat (5) step(); btn_n = 1'b1;
    n = 0;
    repeat (30) begin step(); n += int'(core_rst); end
    check("btn_short", 32'(n), 32'd0);

    // Long button press: latency, hold, release
    btn_n = 1'b0; lat = 0;
    for (int i = 0; i < 100; i++) begin
      step(); lat++;
      if (core_rst) break;
    end
    check("btn_lat", 32'(lat), 32'd11);
    repeat (40 - lat) step();
    check("btn_held", 32'(core_rst), 32'd1);
    btn_n = 1'b1; lat = 0;
    for (int i = 0; i < 100; i++) begin
      step(); lat++;
      if (!core_rst) break;
    end
    check("btn_release", 32'(lat), 32'd4);
    check("btn_cause", 32'(cause[0]), 32'd1);

    // Watchdog serviced, then starved
    cause_clr = 1'b1; step(); cause_clr = 1'b0;
    wdt_limit = 16'd10; wdt_en = 1'b1; n = 0;
    repeat (8) begin
      wdt_kick = 1'b1; step(); wdt_kick = 1'b0; n += int'(core_rst);
      repeat (7) begin step(); n += int'(core_rst); end
    end
    check("wdt_kicked", 32'(n), 32'd0);
    wdt_kick = 1'b1; step(); wdt_kick = 1'b0; lat = 1;
    for (int i = 0; i < 100; i++) begin
      step(); lat++;
      if (core_rst) break;
    end
    check("wdt_lat", 32'(lat), 32'd12);
    check("wdt_cause", 32'(cause), 32'h4);
    for (int i = 0; i < 100; i++) begin
      if (!core_rst) break;
      step();
    end
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      step(); lat++;
      if (core_rst) break;
    end
    check("wdt_restart", 32'(lat), 32'd11);
    wdt_en = 1'b0;
    repeat (20) step();

    // Clear and set in the same cycle
    cause_clr = 1'b1; sw_req = 1'b1; step(); cause_clr = 1'b0; sw_req = 1'b0;
    check("clr_set_cause", 32'(cause), 32'h2);
    repeat (20) step();

    // Request during a pulse does not extend it
    cause_clr = 1'b1; step(); cause_clr = 1'b0;
    sw_req = 1'b1; step(); sw_req = 1'b0;
    n = int'(core_rst);
    repeat (5) begin step(); n += int'(core_rst); end
    cause_clr = 1'b1; step(); cause_clr = 1'b0; n += int'(core_rst);
    sw_req = 1'b1; step(); sw_req = 1'b0; n += int'(core_rst);
    repeat (25) begin step(); n += int'(core_rst); end
    check("ovl_len", 32'(n), 32'd16);
    check("ovl_cause", 32'(cause), 32'h2);

    // Zero limit disables the watchdog
    wdt_en = 1'b1; wdt_limit = 16'd0; n = 0;
    repeat (1000) begin step(); n += int'(core_rst); end
    check("wdt_disabled", 32'(n), 32'd0);

    // Randomized traffic, including mid-pulse resets
    wdt_limit = 16'd12;
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 399) == 0);
      sw_req    = ($urandom_range(0, 59) == 0);
      cause_clr = ($urandom_range(0, 29) == 0);
      wdt_kick  = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 24) == 0) btn_n = ~btn_n;
      if ($urandom_range(0, 199) == 0) wdt_en = ~wdt_en;
      if ($urandom_range(0, 299) == 0) wdt_limit = 16'($urandom_range(0, 24));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
